hilo_mdu: RTL and testbench
===========================

# hilo_mdu

- Iterative multiply/divide unit in the EX stage; sole writer of the HI/LO register pair.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the pipeline with a stall request while an operation is in progress.
- Drives the 66-bit HI/LO forwarding bus that ID stage HI/LO reads consume. The same bus, carried down the pipeline, becomes the HI/LO write port.

## Interface
Parameters:
- none (fixed 32-bit datapath).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_valid  in  1  an MDU instruction is present in EX.
- op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 are no-ops.
- src_a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data).
- src_b  in  32  rt operand (divisor / multiplier).
- flush  in  1  cancels any operation in progress (exception / redirect).
- stall_req  out  1  holds IF/ID/EX while high.
- ex_to_id_2  out  66  {hi_we, lo_we, hi[31:0], lo[31:0]}.
- done  out  1  one-cycle pulse in the cycle a MUL/DIV result is on the bus.

## Operation
- States: IDLE, MUL, DIV, DONE.

IDLE:
- op_valid with op 0/1: latch operands → MUL.
- op_valid with op 2/3: latch operands → DIV.
- op_valid with op 4/5: no state change. The bus combinationally drives {1,0,src_a,0} for MTHI or {0,1,0,src_a} for MTLO in that same cycle; stall_req stays 0.

MUL (shift-add) and DIV (restoring):
- 5-bit iteration counter cleared on entry.
- One bit processed per cycle; the 32nd iteration → DONE.

DONE:
- Registered result on the bus with hi_we=lo_we=1; done=1; stall_req=0.
- Unconditionally → IDLE.
- op_valid is ignored here: it is the same instruction and must not be re-accepted.

Signed operations (MULT, DIV):
- Operate on magnitudes.
- Product negated (64-bit two's complement) if the operand signs differ.
- Quotient negated if the signs differ; remainder takes the dividend's sign.

Results:
- MUL: hi = product[63:32], lo = product[31:0].
- DIV: lo = quotient, hi = remainder.

Boundary cases:
- Divide by zero: still 32 cycles; lo = 32'hFFFF_FFFF, hi = src_a as latched; no sign correction.
- 0x8000_0000 / 0xFFFF_FFFF (DIV): lo = 0x8000_0000, hi = 0.
- flush in any state: → IDLE next edge; bus and done are 0 from that cycle; no HI/LO write results. flush outranks MTHI/MTLO in the same cycle (bus = 0).
- rst: immediate return to IDLE, counter cleared, outputs to reset values.

## Timing
Reset values: stall_req=0, done=0, ex_to_id_2=66'b0, state IDLE.

stall_req:
- Combinational: (IDLE & op_valid & op∈{0..3}) | MUL | DIV.

Latency, accept cycle = cycle 0:
- MUL/DIV iterate in cycles 1–32.
- DONE in cycle 33; stall_req high in cycles 0–32.

Bus:
- ex_to_id_2 is registered in DONE and combinational only for MTHI/MTLO.
- Zero in all other cycles.
- Operands are sampled only at accept; input changes during MUL/DIV have no effect.

## Configuration
Macro MDU_FAST_MUL_EN:
- Defined: MULT/MULTU are computed in one cycle with a 33×33 signed multiply. IDLE → DONE directly; stall_req is high in cycle 0 only, and the result appears in cycle 1.
- Undefined: 32-cycle shift-add path as above.
- DIV/DIVU are unaffected in both cases.

## Structure
Package mdu_pkg holds:
- op encodings (MDU_MULT … MDU_MTLO);
- state encoding;
- HILO_BUS_W = 66 and the field positions of hi_we, lo_we, hi and lo.

Sub-module mdu_div32 is the unsigned restoring divider core:
- start/busy/done handshake;
- 32-cycle quotient/remainder.

hilo_mdu owns the FSM, sign handling, the multiplier and the bus.

## Test plan
- MULT src_a=0xFFFF_FFFE (−2), src_b=3: stall_req high 33 cycles, then the bus = {1,1,0xFFFF_FFFF,0xFFFF_FFFA} with done=1 for 1 cycle.
- DIVU 100/7: lo=14, hi=2. DIV −7/2: lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- DIVU 5/0: lo=0xFFFF_FFFF, hi=5 after 33 cycles.
- MTHI 0x1234_5678 in IDLE: same-cycle bus {1,0,0x1234_5678,0}; stall_req=0; next cycle bus = 0.
- DIV started, flush at cycle 10: IDLE at cycle 11, bus never asserted, stall_req=0. An immediately following MULTU 0xFFFF_FFFF×2 gives hi=1, lo=0xFFFF_FFFE.
- rst asserted mid-MUL: all outputs 0 asynchronously. With MDU_FAST_MUL_EN defined, MULT 3×4 gives done in cycle 1 with lo=12.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: opcodes, FSM states
// and the layout of the 66-bit HI/LO forwarding bus.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    localparam int HILO_BUS_W = 66;
    localparam int HI_WE_BIT  = 65;
    localparam int LO_WE_BIT  = 64;
    localparam int HI_MSB     = 63;
    localparam int HI_LSB     = 32;
    localparam int LO_MSB     = 31;
    localparam int LO_LSB     = 0;

    // Magnitude of an operand; unsigned ops pass through untouched.
    function automatic logic [31:0] f_abs(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_div32.sv
// Unsigned 32-bit restoring divider, one quotient bit per cycle.
// start loads operands; busy covers the 32 iterations; done marks the final one.
module mdu_div32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_flush,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem
);

    logic [31:0] r_q;
    logic [31:0] r_r;
    logic [31:0] r_d;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;

    assign w_shift = {r_r, r_q[31]};
    assign w_diff  = w_shift - {1'b0, r_d};
    assign w_ge    = (w_shift >= {1'b0, r_d});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            r_r    <= '0;
            r_d    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_flush) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_q    <= i_dividend;
            r_r    <= '0;
            r_d    <= i_divisor;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            // Partial remainder stays below the divisor, so 32 bits always hold it.
            r_r   <= w_ge ? w_diff[31:0] : w_shift[31:0];
            r_q   <= {r_q[30:0], w_ge};
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == 5'd31);
    assign o_quot = r_q;
    assign o_rem  = r_r;

endmodule

// File: rtl/hilo_mdu.sv
// EX-stage multiply/divide unit and sole writer of HI/LO; drives the HI/LO forwarding bus.
// Build option MDU_FAST_MUL_EN: single-cycle 33x33 multiply instead of 32-cycle shift-add.
module hilo_mdu
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall_req,
    output logic [65:0] ex_to_id_2,
    output logic        done,
    output logic [1:0]  dbg_state
);

    mdu_state_e  r_state;
    mdu_state_e  w_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_a;
    logic [63:0] r_prod;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;

    logic        w_is_md;
    logic        w_signed;
    logic        w_accept;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_div_busy;
    logic        w_div_done;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [63:0] w_prod_fix;
    logic [31:0] w_hi;
    logic [31:0] w_lo;

    assign w_is_md  = op_valid && (op <= MDU_DIVU);
    assign w_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign w_accept = (r_state == ST_IDLE) && w_is_md && !flush;
    assign w_abs_a  = f_abs(src_a, w_signed);
    assign w_abs_b  = f_abs(src_b, w_signed);

`ifdef MDU_FAST_MUL_EN
    logic signed [32:0] w_ma;
    logic signed [32:0] w_mb;
    logic signed [63:0] w_fast;
    assign w_ma       = {w_signed & src_a[31], src_a};
    assign w_mb       = {w_signed & src_b[31], src_b};
    assign w_fast     = 64'(w_ma) * 64'(w_mb);
    assign w_prod_fix = r_prod;
`else
    logic [31:0] r_mcand;
    logic [32:0] w_add;
    assign w_add      = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_mcand} : 33'd0);
    assign w_prod_fix = r_neg_q ? (~r_prod + 64'd1) : r_prod;
`endif

    mdu_div32 u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_accept && op[1]),
        .i_flush    (flush),
        .i_dividend (w_abs_a),
        .i_divisor  (w_abs_b),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (op[1]) begin
                        w_next = ST_DIV;
                    end else begin
`ifdef MDU_FAST_MUL_EN
                        w_next = ST_DONE;
`else
                        w_next = ST_MUL;
`endif
                    end
                end
            end
            ST_MUL:  if (r_cnt == 5'd31) w_next = ST_DONE;
            ST_DIV:  if (w_div_done) w_next = ST_DONE;
            default: w_next = ST_IDLE;
        endcase
        if (flush) begin
            w_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_prod   <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
`ifndef MDU_FAST_MUL_EN
            r_mcand  <= '0;
`endif
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_a      <= src_a;
            r_is_div <= op[1];
            r_dz     <= (src_b == 32'd0);
            r_neg_q  <= w_signed && (src_a[31] ^ src_b[31]);
            r_neg_r  <= w_signed && src_a[31];
`ifdef MDU_FAST_MUL_EN
            r_prod   <= w_fast;
`else
            r_mcand  <= w_abs_a;
            r_prod   <= {32'd0, w_abs_b};
`endif
        end else if (r_state == ST_MUL) begin
            r_cnt <= r_cnt + 5'd1;
`ifndef MDU_FAST_MUL_EN
            r_prod <= {w_add, r_prod[31:1]};
`endif
        end else if (r_state == ST_DIV) begin
            r_cnt <= r_cnt + 5'd1;
        end
    end

    // Divide by zero reports the raw dividend, bypassing sign correction.
    always_comb begin
        w_hi = w_prod_fix[63:32];
        w_lo = w_prod_fix[31:0];
        if (r_is_div) begin
            if (r_dz) begin
                w_hi = r_a;
                w_lo = 32'hFFFF_FFFF;
            end else begin
                w_hi = r_neg_r ? (~w_rem + 32'd1) : w_rem;
                w_lo = r_neg_q ? (~w_quot + 32'd1) : w_quot;
            end
        end
    end

    always_comb begin
        ex_to_id_2 = '0;
        done       = 1'b0;
        stall_req  = ((r_state == ST_IDLE) && w_is_md) || (r_state == ST_MUL) || w_div_busy;
        if (!flush) begin
            if (r_state == ST_DONE) begin
                ex_to_id_2[HI_WE_BIT]      = 1'b1;
                ex_to_id_2[LO_WE_BIT]      = 1'b1;
                ex_to_id_2[HI_MSB:HI_LSB]  = w_hi;
                ex_to_id_2[LO_MSB:LO_LSB]  = w_lo;
                done                       = 1'b1;
            end else if ((r_state == ST_IDLE) && op_valid && (op == MDU_MTHI)) begin
                ex_to_id_2[HI_WE_BIT]      = 1'b1;
                ex_to_id_2[HI_MSB:HI_LSB]  = src_a;
            end else if ((r_state == ST_IDLE) && op_valid && (op == MDU_MTLO)) begin
                ex_to_id_2[LO_WE_BIT]      = 1'b1;
                ex_to_id_2[LO_MSB:LO_LSB]  = src_a;
            end
        end
    end

    assign dbg_state = r_state;

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed bench for hilo_mdu: multiply/divide results, MTHI/MTLO, flush and reset.
module tb_hilo_mdu;
    import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_req;
    logic [65:0] ex_to_id_2;
    logic        done;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    hilo_mdu dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .stall_req  (stall_req),
        .ex_to_id_2 (ex_to_id_2),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_quiet(input string tag);
        chk1({tag, "_stall"}, stall_req, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk({tag, "_bus"}, ex_to_id_2, 66'd0);
    endtask

    // Accept in cycle 0, hold op_valid through DONE, scramble operands after accept.
    task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        lat = (o <= MDU_MULTU) ? MUL_LAT : DIV_LAT;
        @(posedge clk); #1;
        op_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            chk1({tag, "_stall"}, stall_req, 1'b1);
            chk1({tag, "_done_early"}, done, 1'b0);
            chk({tag, "_bus_early"}, ex_to_id_2, 66'd0);
            @(posedge clk); #1;
            src_a = ~a;
            src_b = a ^ b ^ 32'h5A5A_0001;
        end
        @(negedge clk);
        chk1({tag, "_stall_done"}, stall_req, 1'b0);
        chk1({tag, "_done"}, done, 1'b1);
        chk({tag, "_result"}, ex_to_id_2, {2'b11, exp_hi, exp_lo});
        @(posedge clk); #1;
        op_valid = 1'b0;
        op       = 3'd7;
        @(negedge clk);
        chk_idle_quiet({tag, "_after"});
        chk({tag, "_state"}, {64'd0, dbg_state}, 66'd0);
    endtask

    initial begin
        rst      = 1'b1;
        op_valid = 1'b0;
        op       = 3'd7;
        src_a    = '0;
        src_b    = '0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_quiet("reset");
        chk("reset_state", {64'd0, dbg_state}, 66'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_md("mult_m2x3",    MDU_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_md("mult_min_sq",  MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_md("multu_max_sq", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_md("divu_100_7",   MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
        run_md("div_m7_2",     MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("div_100_m7",   MDU_DIV,   32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2);
        run_md("divu_5_0",     MDU_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
        run_md("div_m7_0",     MDU_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_md("div_ovf",      MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);

        // MTHI / MTLO drive the bus in the same cycle only
        @(posedge clk); #1;
        op_valid = 1'b1; op = MDU_MTHI; src_a = 32'h1234_5678; src_b = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("mthi_bus", ex_to_id_2, {2'b10, 32'h1234_5678, 32'd0});
        chk1("mthi_stall", stall_req, 1'b0);
        chk1("mthi_done", done, 1'b0);
        @(posedge clk); #1;
        op = MDU_MTLO; src_a = 32'hCAFE_F00D;
        @(negedge clk);
        chk("mtlo_bus", ex_to_id_2, {2'b01, 32'd0, 32'hCAFE_F00D});
        chk1("mtlo_stall", stall_req, 1'b0);
        @(posedge clk); #1;
        op = MDU_MTHI; flush = 1'b1;
        @(negedge clk);
        chk("mthi_flush_bus", ex_to_id_2, 66'd0);
        @(posedge clk); #1;
        flush = 1'b0; op = 3'd6;
        @(negedge clk);
        chk_idle_quiet("noop6");
        @(posedge clk); #1;
        op_valid = 1'b0; op = 3'd7;
        @(negedge clk);
        chk_idle_quiet("after_mt");
        chk("after_mt_state", {64'd0, dbg_state}, 66'd0);

        // DIV flushed in cycle 10
        @(posedge clk); #1;
        op_valid = 1'b1; op = MDU_DIV; src_a = 32'd100; src_b = 32'd7;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk1("flushdiv_stall", stall_req, 1'b1);
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flushdiv_bus_c10", ex_to_id_2, 66'd0);
        chk1("flushdiv_done_c10", done, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; op_valid = 1'b0; op = 3'd7;
        @(negedge clk);
        chk_idle_quiet("flushdiv_c11");
        chk("flushdiv_state_c11", {64'd0, dbg_state}, 66'd0);
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk_idle_quiet("flushdiv_quiet");
        end
        run_md("multu_after_flush", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE);

        // Asynchronous reset in the middle of a multiply
        @(posedge clk); #1;
        op_valid = 1'b1; op = MDU_MULT; src_a = 32'd3; src_b = 32'd4;
        repeat (5) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1; op_valid = 1'b0; op = 3'd7;
        #1;
        chk_idle_quiet("rst_mid_mul");
        chk("rst_mid_mul_state", {64'd0, dbg_state}, 66'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle_quiet("rst_release");

        run_md("mult_3x4", MDU_MULT, 32'd3, 32'd4, 32'd0, 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
